// File: rtl/back_color_gen_pkg.sv
// Shared types and constants for the playfield backdrop colour generator.
//   rgb12_t     : packed 4:4:4 colour
//   LEVEL_TOP/  : per-level gradient endpoints (row 0 / floor line)
//   LEVEL_BOT
//   BAYER       : 2x2 ordered-dither thresholds in 1/16 steps, indexed {y[0], x[0]}
//   clamp_level : maps the 10-bit game level onto the 8 LUT entries
package back_color_gen_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam int unsigned NUM_LEVELS = 8;

  localparam rgb12_t LEVEL_TOP [NUM_LEVELS] = '{
    rgb12_t'(12'h000), rgb12_t'(12'h26A), rgb12_t'(12'h400), rgb12_t'(12'h040),
    rgb12_t'(12'h204), rgb12_t'(12'h024), rgb12_t'(12'h420), rgb12_t'(12'h111)
  };

  localparam rgb12_t LEVEL_BOT [NUM_LEVELS] = '{
    rgb12_t'(12'h000), rgb12_t'(12'hACE), rgb12_t'(12'hC84), rgb12_t'(12'h6C6),
    rgb12_t'(12'hA4C), rgb12_t'(12'h4CE), rgb12_t'(12'hE86), rgb12_t'(12'hFFF)
  };

  localparam logic [3:0] BAYER [4] = '{4'd0, 4'd8, 4'd12, 4'd4};

  function automatic logic [2:0] clamp_level(input logic [9:0] level);
    return (level > 10'd7) ? 3'd7 : level[2:0];
  endfunction

endpackage

// File: rtl/back_color_gen_if.sv
// Bus between the VGA sync/counter block and the backdrop colour generator.
//   master : timing source (drives sync, position, level, blank; reads colour)
//   slave  : back_color_gen (reads timing, drives red/green/blue_back, fade_busy)
interface back_color_gen_if;
  logic       hs;
  logic       vs;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] level;
  logic       blank;
  logic [3:0] red_back;
  logic [3:0] green_back;
  logic [3:0] blue_back;
  logic       fade_busy;

  modport master (
    output hs, vs, DrawX, DrawY, level, blank,
    input  red_back, green_back, blue_back, fade_busy
  );

  modport slave (
    input  hs, vs, DrawX, DrawY, level, blank,
    output red_back, green_back, blue_back, fade_busy
  );
endinterface

// File: rtl/back_color_gen_rgb_lerp.sv
// Combinational per-channel linear blend: y = a + ((b - a) * t >>> S).
// FRAC extra fraction bits are kept below the integer result.
//   a, b          : endpoint colours
//   t             : blend weight, TW bits (t = 2^S yields b exactly)
//   y_r, y_g, y_b : blended channels, 4 integer + FRAC fraction bits
module back_color_gen_rgb_lerp
  import back_color_gen_pkg::*;
#(
  parameter int unsigned TW   = 5,
  parameter int unsigned S    = 4,
  parameter int unsigned FRAC = 0
) (
  input  rgb12_t            a,
  input  rgb12_t            b,
  input  logic [TW-1:0]     t,
  output logic [3+FRAC:0]   y_r,
  output logic [3+FRAC:0]   y_g,
  output logic [3+FRAC:0]   y_b
);

  localparam int unsigned PW = 4 + S + TW + 3;

  // a is folded in pre-shift so the arithmetic shift floors the whole sum,
  // which equals a + floor((b - a) * t / 2^S).
  function automatic logic [3+FRAC:0] lerp_ch(input logic [3:0] ca, input logic [3:0] cb);
    logic signed [5:0]    diff;
    logic signed [PW-1:0] a_w, d_w, t_w, acc;
    diff = $signed({2'b00, cb}) - $signed({2'b00, ca});
    a_w  = PW'(ca);
    d_w  = PW'(diff);
    t_w  = PW'(t);
    acc  = (a_w <<< S) + d_w * t_w;
    return (4 + FRAC)'(acc >>> (S - FRAC));
  endfunction

  assign y_r = lerp_ch(a.r, b.r);
  assign y_g = lerp_ch(a.g, b.g);
  assign y_b = lerp_ch(a.b, b.b);

endmodule

// File: rtl/back_color_gen.sv
// Playfield backdrop colour generator. Produces one colour per line from a
// per-level vertical gradient and crossfades between levels at frame rate.
//   vga_clk  : pixel clock
//   reset_n  : asynchronous active-low reset
//   bus      : back_color_gen_if.slave (hs/vs/DrawX/DrawY/level/blank in,
//              red_back/green_back/blue_back/fade_busy out)
// Optional build macro DITHER_EN: keep 4 fraction bits in the line blend and
// apply a 2x2 Bayer dither per pixel; otherwise the colour is flat per line.
module back_color_gen
  import back_color_gen_pkg::*;
#(
  parameter int unsigned FADE_LOG2  = 4,
  parameter int unsigned BAND_SHIFT = 5,
  parameter int unsigned PLAY_H     = 398
) (
  input logic              vga_clk,
  input logic              reset_n,
  back_color_gen_if.slave  bus
);

  localparam int unsigned AW = FADE_LOG2 + 1;
  localparam logic [AW-1:0] ALPHA_FULL = {1'b1, {FADE_LOG2{1'b0}}};

`ifdef DITHER_EN
  localparam int unsigned GFRAC = 4;
`else
  localparam int unsigned GFRAC = 0;
`endif

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FADE = 1'b1;

  // Sync edge detection
  logic hs_q, vs_q;
  logic line_start, frame_start;

  assign line_start  = hs_q & ~bus.hs;
  assign frame_start = vs_q & ~bus.vs;

  // Fade controller state
  logic [0:0]    state_q, state_d;
  logic [2:0]    cur_level_q, cur_level_d;
  rgb12_t        old_top_q, old_top_d, old_bot_q, old_bot_d;
  rgb12_t        new_top_q, new_top_d, new_bot_q, new_bot_d;
  logic [AW-1:0] alpha_q, alpha_d;
  logic          fade_busy_q, fade_busy_d;
  rgb12_t        eff_top_q, eff_bot_q, eff_top_d, eff_bot_d;
  logic [2:0]    lvl_c;

  assign lvl_c = clamp_level(bus.level);

  always_comb begin
    state_d     = state_q;
    cur_level_d = cur_level_q;
    old_top_d   = old_top_q;
    old_bot_d   = old_bot_q;
    new_top_d   = new_top_q;
    new_bot_d   = new_bot_q;
    alpha_d     = alpha_q;
    fade_busy_d = fade_busy_q;
    if (frame_start) begin
      if (lvl_c != cur_level_q) begin
        // Restart from whatever is on screen now so a mid-fade change is seamless.
        old_top_d   = eff_top_q;
        old_bot_d   = eff_bot_q;
        new_top_d   = LEVEL_TOP[lvl_c];
        new_bot_d   = LEVEL_BOT[lvl_c];
        cur_level_d = lvl_c;
        alpha_d     = '0;
        fade_busy_d = 1'b1;
        state_d     = ST_FADE;
      end else if (state_q == ST_FADE) begin
        alpha_d = alpha_q + AW'(1);
        if (alpha_d == ALPHA_FULL) begin
          state_d     = ST_IDLE;
          fade_busy_d = 1'b0;
        end
      end
    end
  end

  // Effective gradient endpoints for the current fade position
  back_color_gen_rgb_lerp #(
    .TW   (AW),
    .S    (FADE_LOG2),
    .FRAC (0)
  ) u_fade_top (
    .a   (old_top_q),
    .b   (new_top_q),
    .t   (alpha_q),
    .y_r (eff_top_d.r),
    .y_g (eff_top_d.g),
    .y_b (eff_top_d.b)
  );

  back_color_gen_rgb_lerp #(
    .TW   (AW),
    .S    (FADE_LOG2),
    .FRAC (0)
  ) u_fade_bot (
    .a   (old_bot_q),
    .b   (new_bot_q),
    .t   (alpha_q),
    .y_r (eff_bot_d.r),
    .y_g (eff_bot_d.g),
    .y_b (eff_bot_d.b)
  );

  // Line pipeline: weight register, then blend register
  logic [8:0]       band;
  logic [3:0]       w_d, w_q;
  logic             line_d_q;
  logic [3+GFRAC:0] col_r_d, col_g_d, col_b_d;
  logic [3+GFRAC:0] col_r_q, col_g_q, col_b_q;

  always_comb begin
    band = bus.DrawY[8:0] >> BAND_SHIFT;
    if (bus.DrawY >= 10'(PLAY_H) || band > 9'd15) begin
      w_d = 4'd15;
    end else begin
      w_d = band[3:0];
    end
  end

  back_color_gen_rgb_lerp #(
    .TW   (4),
    .S    (4),
    .FRAC (GFRAC)
  ) u_grad (
    .a   (eff_top_q),
    .b   (eff_bot_q),
    .t   (w_q),
    .y_r (col_r_d),
    .y_g (col_g_d),
    .y_b (col_b_d)
  );

  // Output stage
  rgb12_t out_d, out_q;

`ifdef DITHER_EN
  logic [3:0] thresh;
  logic       unused_drawx;
  assign unused_drawx = ^bus.DrawX[9:1];

  function automatic logic [3:0] dither_ch(input logic [7:0] c, input logic [3:0] th);
    logic [8:0] s;
    logic [4:0] q;
    s = 9'(c) + 9'(th);
    q = 5'(s >> 4);
    return q[4] ? 4'hF : q[3:0];
  endfunction

  always_comb begin
    out_d  = '0;
    thresh = BAYER[{bus.DrawY[0], bus.DrawX[0]}];
    if (bus.blank) begin
      out_d.r = dither_ch(col_r_q, thresh);
      out_d.g = dither_ch(col_g_q, thresh);
      out_d.b = dither_ch(col_b_q, thresh);
    end
  end
`else
  logic unused_drawx;
  assign unused_drawx = ^bus.DrawX;

  always_comb begin
    out_d = '0;
    if (bus.blank) begin
      out_d.r = col_r_q;
      out_d.g = col_g_q;
      out_d.b = col_b_q;
    end
  end
`endif

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      state_q     <= ST_IDLE;
      cur_level_q <= 3'd0;
      old_top_q   <= LEVEL_TOP[0];
      old_bot_q   <= LEVEL_BOT[0];
      new_top_q   <= LEVEL_TOP[0];
      new_bot_q   <= LEVEL_BOT[0];
      alpha_q     <= ALPHA_FULL;
      fade_busy_q <= 1'b0;
      eff_top_q   <= LEVEL_TOP[0];
      eff_bot_q   <= LEVEL_BOT[0];
      w_q         <= 4'd0;
      line_d_q    <= 1'b0;
      col_r_q     <= '0;
      col_g_q     <= '0;
      col_b_q     <= '0;
      out_q       <= '0;
    end else begin
      hs_q        <= bus.hs;
      vs_q        <= bus.vs;
      state_q     <= state_d;
      cur_level_q <= cur_level_d;
      old_top_q   <= old_top_d;
      old_bot_q   <= old_bot_d;
      new_top_q   <= new_top_d;
      new_bot_q   <= new_bot_d;
      alpha_q     <= alpha_d;
      fade_busy_q <= fade_busy_d;
      eff_top_q   <= eff_top_d;
      eff_bot_q   <= eff_bot_d;
      line_d_q    <= line_start;
      if (line_start) begin
        w_q <= w_d;
      end
      if (line_d_q) begin
        col_r_q <= col_r_d;
        col_g_q <= col_g_d;
        col_b_q <= col_b_d;
      end
      out_q <= out_d;
    end
  end

  assign bus.red_back   = out_q.r;
  assign bus.green_back = out_q.g;
  assign bus.blue_back  = out_q.b;
  assign bus.fade_busy  = fade_busy_q;

endmodule

// File: doc/back_color_gen.md
Name: back_color_gen

Overview:
Generates the per-line playfield backdrop colour (red_back/green_back/blue_back) that the background compositor shows in the play area above the floor strip. Each level has a vertical top-to-bottom gradient taken from a package LUT. A level change triggers a frame-rate crossfade from the old level's gradient to the new one. The block sits directly upstream of the background compositor, driven by the VGA sync/counter block.

Parameters:
FADE_LOG2, 4, crossfade length is 2^FADE_LOG2 frames; blend shift amount
BAND_SHIFT, 5, gradient band height is 2^BAND_SHIFT lines
PLAY_H, 398, first non-playfield row; rows >= PLAY_H use band 15

Ports:
vga_clk  in  1  pixel clock; all state on posedge
reset_n  in  1  asynchronous, active-low reset
hs  in  1  horizontal sync, active low
vs  in  1  vertical sync, active low
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
level  in  10  current game level; values >7 treated as 7
blank  in  1  0 = blanking interval
red_back  out  4  backdrop red
green_back  out  4  backdrop green
blue_back  out  4  backdrop blue
fade_busy  out  1  1 while a crossfade is in progress

Behaviour:
- Reset (async, reset_n=0): outputs 0; fade_busy=0; cur_level=0; old_col=new_col=LUT[0]; alpha=2^FADE_LOG2; state IDLE.
- Edge detect: hs and vs are registered once. line_start = hs falling edge; frame_start = vs falling edge.
- Level clamp: lvl_c = (level>7) ? 7 : level[2:0].
- FSM IDLE -> FADE: on frame_start with lvl_c != cur_level:
  - old_col <= current effective top/bot pair.
  - new_col <= LUT[lvl_c]; cur_level <= lvl_c; alpha <= 0; fade_busy <= 1.
- FADE: on each frame_start, alpha <= alpha+1.
- FADE -> IDLE: when alpha reaches 2^FADE_LOG2, enter IDLE and clear fade_busy.
- Level change during FADE, at frame_start: old_col snaps to the current effective pair, new_col is reloaded, alpha restarts at 0. No discontinuity.
- Effective pair: eff = old + (((new-old)*alpha) >>> FADE_LOG2).
  - Evaluated per channel, per top and bot, in signed 6-bit arithmetic.
  - Registered one cycle after frame_start.
- Gradient weight per line, sampled from DrawY on line_start: w = (DrawY < PLAY_H) ? DrawY[8:BAND_SHIFT] (saturated to 4 bits) : 15.
- Line colour: c = eff_top + (((eff_bot-eff_top)*w) >>> 4), per channel.
  - Pipelined in 2 stages: weight register, then blend register.
  - The result lands line_start+2 cycles, well inside hblank.
- Output register: holds the line colour for the whole line; forced to 0 while blank=0.
- Simultaneous line_start and frame_start: the frame update happens first. The line blend uses the previous eff, which is acceptable because it falls in vblank.

Optional Feature:
DITHER_EN
- Defined:
  - The line blend keeps 4 fractional bits.
  - Each channel adds a 2x2 Bayer threshold indexed by {DrawY[0],DrawX[0]} (values 0,8,12,4 of 16) before truncation, saturating at 15.
  - Output then changes per pixel, with 1-cycle latency from DrawX.
- Undefined: plain truncation; colour is constant across the line.

Decomposition:
- Package bg_pkg:
  - rgb12_t struct (r,g,b 4-bit).
  - LEVEL_TOP[0:7] and LEVEL_BOT[0:7] LUTs; entries include L0 = 0x000/0x000 and L1 = 0x26A/0xACE.
  - Bayer constants.
- Sub-module rgb_lerp: combinational per-channel a + ((b-a)*t >>> S). It is instantiated for the fade blend (top, bot) and the gradient blend.

Test Plan:
- Reset: assert reset_n=0 mid-line -> all outputs 0 immediately; after release, level=0 gives 0x000 everywhere, fade_busy=0.
- Steady level 1, no dither -> DrawY=0 line outputs 0x26A; DrawY=396 (w=12) outputs 0x8AD; blank=0 outputs 0x000.
- Level 0->1 at a frame_start -> fade_busy=1; 8 frames later, DrawY=0 outputs 0x135; after 16 frames outputs 0x26A and fade_busy=0.
- Level changed again to 2 at alpha=8 -> next frame line 0 equals the prior 0x135 blend start, alpha=0; no jump larger than 1 LSB per channel between consecutive frames.
- level=9 -> behaves identically to level=7; changing level 7->9 starts no fade.
- With DITHER_EN, level 1, DrawY=396 -> the four pixels of a 2x2 block differ by at most 1 LSB per channel, and their average matches the fractional blend.
